// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with ALU control decode, EX/MEM and MEM/WB operand
// forwarding, and load-use hazard detection.
module id_ex_stage #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         id_valid,
    input  logic [4:0]   id_rs,
    input  logic [4:0]   id_rt,
    input  logic [4:0]   id_rd,
    input  logic [W-1:0] id_rs_data,
    input  logic [W-1:0] id_rt_data,
    input  logic [W-1:0] id_imm,
    input  logic [4:0]   id_shamt,
    input  logic [5:0]   id_funct,
    input  logic [1:0]   id_alu_op,
    input  logic         id_alu_src,
    input  logic         id_reg_dst,
    input  logic         id_reg_write,
    input  logic         id_mem_read,
    input  logic         id_mem_write,
    input  logic         id_mem_to_reg,
    input  logic         id_branch,
    input  logic         flush,
    input  logic         exm_reg_write,
    input  logic [4:0]   exm_rd,
    input  logic [W-1:0] exm_result,
    input  logic         mwb_reg_write,
    input  logic [4:0]   mwb_rd,
    input  logic [W-1:0] mwb_data,
    output logic         hazard_stall,
    output logic         ex_valid,
    output logic [3:0]   alu_ctrl,
    output logic [W-1:0] alu_in1,
    output logic [W-1:0] alu_in2,
    output logic [W-1:0] ex_store_data,
    output logic [4:0]   ex_dest,
    output logic         ex_reg_write,
    output logic         ex_mem_read,
    output logic         ex_mem_write,
    output logic         ex_mem_to_reg,
    output logic         ex_branch,
    output logic         ex_illegal
);

    localparam int unsigned RW = 5;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0011;
    localparam logic [3:0] ALU_SLL = 4'b0100;
    localparam logic [3:0] ALU_SRL = 4'b0101;
    localparam logic [3:0] ALU_SLT = 4'b0110;

    logic [RW-1:0] ex_rs_q;
    logic [RW-1:0] ex_rt_q;
    logic [W-1:0]  ex_rs_data_q;
    logic [W-1:0]  ex_rt_data_q;
    logic [W-1:0]  ex_imm_q;
    logic [RW-1:0] ex_shamt_q;
    logic          ex_alu_src_q;

    logic [3:0]    dec_code;
    logic          dec_illegal;
    logic          bubble;
    logic [W-1:0]  fwd_rs;
    logic [W-1:0]  fwd_rt;
    logic          is_shift;

    // ALU control decode from ALUOp / funct
    always_comb begin
        dec_code    = ALU_ADD;
        dec_illegal = 1'b0;
        case (id_alu_op)
            2'b00: dec_code = ALU_ADD;
            2'b01: dec_code = ALU_SUB;
            2'b11: dec_code = ALU_OR;
            default: begin
                case (id_funct)
                    6'b100000: dec_code = ALU_ADD;
                    6'b100010: dec_code = ALU_SUB;
                    6'b100100: dec_code = ALU_AND;
                    6'b100101: dec_code = ALU_OR;
                    6'b101010: dec_code = ALU_SLT;
                    6'b000000: dec_code = ALU_SLL;
                    6'b000010: dec_code = ALU_SRL;
                    default: begin
                        dec_code    = ALU_ADD;
                        dec_illegal = 1'b1;
                    end
                endcase
            end
        endcase
    end

    // Load in EX whose destination is read by the instruction in decode
    always_comb begin
        hazard_stall = ex_valid && ex_mem_read && (ex_dest != '0) && id_valid &&
                       ((ex_dest == id_rs) || (ex_dest == id_rt));
    end

    assign bubble = flush || hazard_stall;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_valid      <= 1'b0;
            alu_ctrl      <= ALU_ADD;
            ex_illegal    <= 1'b0;
            ex_dest       <= '0;
            ex_reg_write  <= 1'b0;
            ex_mem_read   <= 1'b0;
            ex_mem_write  <= 1'b0;
            ex_mem_to_reg <= 1'b0;
            ex_branch     <= 1'b0;
            ex_rs_q       <= '0;
            ex_rt_q       <= '0;
            ex_rs_data_q  <= '0;
            ex_rt_data_q  <= '0;
            ex_imm_q      <= '0;
            ex_shamt_q    <= '0;
            ex_alu_src_q  <= 1'b0;
        end else begin
            ex_rs_q      <= id_rs;
            ex_rt_q      <= id_rt;
            ex_rs_data_q <= id_rs_data;
            ex_rt_data_q <= id_rt_data;
            ex_imm_q     <= id_imm;
            ex_shamt_q   <= id_shamt;
            ex_alu_src_q <= id_alu_src;
            ex_dest      <= id_reg_dst ? id_rd : id_rt;
            if (bubble) begin
                ex_valid      <= 1'b0;
                alu_ctrl      <= ALU_ADD;
                ex_illegal    <= 1'b0;
                ex_reg_write  <= 1'b0;
                ex_mem_read   <= 1'b0;
                ex_mem_write  <= 1'b0;
                ex_mem_to_reg <= 1'b0;
                ex_branch     <= 1'b0;
            end else begin
                ex_valid      <= id_valid;
                alu_ctrl      <= dec_code;
                ex_illegal    <= dec_illegal;
                ex_reg_write  <= id_reg_write;
                ex_mem_read   <= id_mem_read;
                ex_mem_write  <= id_mem_write;
                ex_mem_to_reg <= id_mem_to_reg;
                ex_branch     <= id_branch;
            end
        end
    end

    // Forwarding: EX/MEM (younger) beats MEM/WB; r0 is never forwarded
    always_comb begin
        fwd_rs = ex_rs_data_q;
        if (exm_reg_write && (exm_rd != '0) && (exm_rd == ex_rs_q)) begin
            fwd_rs = exm_result;
        end else if (mwb_reg_write && (mwb_rd != '0) && (mwb_rd == ex_rs_q)) begin
            fwd_rs = mwb_data;
        end
        fwd_rt = ex_rt_data_q;
        if (exm_reg_write && (exm_rd != '0) && (exm_rd == ex_rt_q)) begin
            fwd_rt = exm_result;
        end else if (mwb_reg_write && (mwb_rd != '0) && (mwb_rd == ex_rt_q)) begin
            fwd_rt = mwb_data;
        end
    end

    assign is_shift = (alu_ctrl == ALU_SLL) || (alu_ctrl == ALU_SRL);

    // Shifts take the value from rt and the amount from shamt
    always_comb begin
        alu_in1       = is_shift ? fwd_rt : fwd_rs;
        alu_in2       = is_shift ? W'(ex_shamt_q) : (ex_alu_src_q ? ex_imm_q : fwd_rt);
        ex_store_data = fwd_rt;
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Randomized bench for id_ex_stage against a behavioural pipeline-slot model,
// plus directed reset, decode, forwarding, load-use and flush scenarios.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic [4:0]  id_rs, id_rt, id_rd, id_shamt;
    logic [31:0] id_rs_data, id_rt_data, id_imm;
    logic [5:0]  id_funct;
    logic [1:0]  id_alu_op;
    logic        id_alu_src, id_reg_dst, id_reg_write, id_mem_read;
    logic        id_mem_write, id_mem_to_reg, id_branch, flush;
    logic        exm_reg_write, mwb_reg_write;
    logic [4:0]  exm_rd, mwb_rd;
    logic [31:0] exm_result, mwb_data;
    logic        hazard_stall, ex_valid, ex_illegal;
    logic [3:0]  alu_ctrl;
    logic [31:0] alu_in1, alu_in2, ex_store_data;
    logic [4:0]  ex_dest;
    logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch;

    int n_checks = 0;
    int n_fail   = 0;

    // Model of the instruction currently held in the EX slot
    bit          m_init = 0;
    bit          m_valid, m_illegal, m_rw, m_mr, m_mw, m_m2r, m_br, m_src;
    logic [3:0]  m_code;
    logic [4:0]  m_dest, m_rs, m_rt, m_shamt;
    logic [31:0] m_rsd, m_rtd, m_imm;

    logic [5:0] ftab [7] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h00, 6'h02};
    logic [3:0] ctab [7] = '{4'd2, 4'd3, 4'd0, 4'd1, 4'd6, 4'd4, 4'd5};
    logic [3:0] otab [4] = '{4'd2, 4'd3, 4'd2, 4'd1};

    id_ex_stage #(.W(32)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_shamt(id_shamt), .id_funct(id_funct), .id_alu_op(id_alu_op),
        .id_alu_src(id_alu_src), .id_reg_dst(id_reg_dst), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .id_mem_to_reg(id_mem_to_reg), .id_branch(id_branch), .flush(flush),
        .exm_reg_write(exm_reg_write), .exm_rd(exm_rd), .exm_result(exm_result),
        .mwb_reg_write(mwb_reg_write), .mwb_rd(mwb_rd), .mwb_data(mwb_data),
        .hazard_stall(hazard_stall), .ex_valid(ex_valid), .alu_ctrl(alu_ctrl),
        .alu_in1(alu_in1), .alu_in2(alu_in2), .ex_store_data(ex_store_data),
        .ex_dest(ex_dest), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg),
        .ex_branch(ex_branch), .ex_illegal(ex_illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic void ref_decode(input logic [1:0] op, input logic [5:0] f,
                                       output logic [3:0] c, output bit ill);
        c   = otab[op];
        ill = 0;
        if (op == 2'b10) begin
            c   = 4'd2;
            ill = 1;
            for (int i = 0; i < 7; i++)
                if (ftab[i] == f) begin
                    c   = ctab[i];
                    ill = 0;
                end
        end
    endfunction

    function automatic logic [31:0] fwd(input logic [4:0] r, input logic [31:0] d);
        if (r == 0) return d;
        if (exm_reg_write && exm_rd == r) return exm_result;
        if (mwb_reg_write && mwb_rd == r) return mwb_data;
        return d;
    endfunction

    task automatic check_comb(input bit stall_e);
        logic [31:0] frs, frt;
        bit sh;
        check("hazard_stall", hazard_stall, stall_e);
        if (m_valid) begin
            frs = fwd(m_rs, m_rsd);
            frt = fwd(m_rt, m_rtd);
            sh  = (m_code == 4'd4) || (m_code == 4'd5);
            check("alu_in1", alu_in1, sh ? frt : frs);
            check("alu_in2", alu_in2, sh ? {27'd0, m_shamt} : (m_src ? m_imm : frt));
            check("store_data", ex_store_data, frt);
        end
    endtask

    task automatic check_regs();
        check("ex_valid", ex_valid, m_valid);
        check("alu_ctrl", alu_ctrl, m_code);
        check("ex_illegal", ex_illegal, m_illegal);
        check("ex_dest", ex_dest, m_dest);
        check("ex_ctrl", {ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch},
              {m_rw, m_mr, m_mw, m_m2r, m_br});
    endtask

    // One clock: check combinational paths, advance model, check registers
    task automatic tick();
        bit stall_e;
        #1;
        stall_e = m_valid && m_mr && (m_dest != 0) && id_valid &&
                  ((m_dest == id_rs) || (m_dest == id_rt));
        if (m_init) check_comb(stall_e);
        @(posedge clk);
        m_rs = id_rs; m_rt = id_rt; m_rsd = id_rs_data; m_rtd = id_rt_data;
        m_imm = id_imm; m_shamt = id_shamt; m_src = id_alu_src;
        m_dest = id_reg_dst ? id_rd : id_rt;
        if (!rst_n) begin
            m_init = 1; m_valid = 0; m_code = 4'd2; m_illegal = 0; m_dest = 0;
            {m_rw, m_mr, m_mw, m_m2r, m_br} = '0;
        end else if (flush || stall_e) begin
            m_valid = 0; m_code = 4'd2; m_illegal = 0;
            {m_rw, m_mr, m_mw, m_m2r, m_br} = '0;
        end else begin
            m_valid = id_valid;
            ref_decode(id_alu_op, id_funct, m_code, m_illegal);
            {m_rw, m_mr, m_mw, m_m2r, m_br} =
                {id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_branch};
        end
        #1;
        if (m_init) check_regs();
        @(negedge clk);
    endtask

    task automatic rand_inputs();
        id_valid = ($urandom_range(0, 4) != 0);
        id_rs = 5'($urandom_range(0, 3)); id_rt = 5'($urandom_range(0, 3));
        id_rd = 5'($urandom_range(0, 3)); id_shamt = 5'($urandom);
        id_rs_data = $urandom; id_rt_data = $urandom; id_imm = $urandom;
        id_funct = ($urandom_range(0, 4) != 0) ? ftab[$urandom_range(0, 6)] : 6'($urandom);
        id_alu_op = 2'($urandom);
        {id_alu_src, id_reg_dst, id_reg_write, id_mem_read, id_mem_write,
         id_mem_to_reg, id_branch} = 7'($urandom);
        flush = ($urandom_range(0, 9) == 0);
        exm_reg_write = 1'($urandom); exm_rd = 5'($urandom_range(0, 3)); exm_result = $urandom;
        mwb_reg_write = 1'($urandom); mwb_rd = 5'($urandom_range(0, 3)); mwb_data = $urandom;
    endtask

    task automatic quiet_inputs();
        id_valid = 1; id_rs = 0; id_rt = 0; id_rd = 0; id_shamt = 0;
        id_rs_data = 0; id_rt_data = 0; id_imm = 0; id_funct = 6'h20; id_alu_op = 0;
        {id_alu_src, id_reg_dst, id_reg_write, id_mem_read, id_mem_write,
         id_mem_to_reg, id_branch} = '0;
        flush = 0; rst_n = 1;
        exm_reg_write = 0; exm_rd = 0; exm_result = 0;
        mwb_reg_write = 0; mwb_rd = 0; mwb_data = 0;
    endtask

    task automatic set_load_r8();
        quiet_inputs();
        id_rs = 5'd1; id_rt = 5'd8; id_alu_src = 1; id_imm = 32'h4;
        id_mem_read = 1; id_reg_write = 1; id_mem_to_reg = 1;
    endtask

    task automatic set_add_r9_r8_r8();
        quiet_inputs();
        id_rs = 5'd8; id_rt = 5'd8; id_rd = 5'd9; id_reg_dst = 1; id_reg_write = 1;
        id_alu_op = 2'b10; id_funct = 6'h20;
        id_rs_data = 32'h55; id_rt_data = 32'h66;
    endtask

    logic [5:0] dfun [8] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h00, 6'h02, 6'h03};
    logic [3:0] dexp [8] = '{4'd2, 4'd3, 4'd0, 4'd1, 4'd6, 4'd4, 4'd5, 4'd2};

    initial begin
        // Reset with random decode inputs
        rand_inputs();
        rst_n = 0;
        tick();
        rand_inputs();
        rst_n = 0;
        tick();
        check("reset_valid", ex_valid, 0);
        check("reset_alu_ctrl", alu_ctrl, 4'b0010);
        check("reset_ctrl", {ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch}, 0);
        #1 check("reset_stall", hazard_stall, 0);

        // ALU control decode
        for (int i = 0; i < 8; i++) begin
            quiet_inputs();
            id_alu_op = 2'b10; id_funct = dfun[i];
            tick();
            check($sformatf("decode_f%02h", dfun[i]), alu_ctrl, dexp[i]);
            check($sformatf("illegal_f%02h", dfun[i]), ex_illegal, (i == 7) ? 1 : 0);
        end
        quiet_inputs(); id_alu_op = 2'b00; tick(); check("decode_op00", alu_ctrl, 4'b0010);
        quiet_inputs(); id_alu_op = 2'b01; tick(); check("decode_op01", alu_ctrl, 4'b0011);
        quiet_inputs(); id_alu_op = 2'b11; tick(); check("decode_op11", alu_ctrl, 4'b0001);

        // Forwarding priority
        quiet_inputs();
        id_rs = 5'd5; id_rs_data = 32'h1;
        tick();
        id_valid = 0;
        exm_reg_write = 1; exm_rd = 5'd5; exm_result = 32'hAA;
        mwb_reg_write = 1; mwb_rd = 5'd5; mwb_data = 32'hBB;
        #1 check("fwd_exm", alu_in1, 32'hAA);
        exm_reg_write = 0;
        #1 check("fwd_mwb", alu_in1, 32'hBB);
        exm_reg_write = 1; exm_rd = 0; mwb_rd = 0;
        #1 check("fwd_none", alu_in1, 32'h1);
        tick();

        // Immediate and shift operand select
        quiet_inputs();
        id_rs = 5'd1; id_rs_data = 32'h7; id_imm = 32'hFFFF_FFFC; id_alu_src = 1;
        tick();
        #1 check("imm_in2", alu_in2, 32'hFFFF_FFFC);
        quiet_inputs();
        id_alu_op = 2'b10; id_funct = 6'h00; id_rt = 5'd2; id_rt_data = 32'h1; id_shamt = 5'd3;
        tick();
        #1 check("sll_in1", alu_in1, 32'h1);
        check("sll_in2", alu_in2, 32'h3);

        // Load-use: one bubble, then the held add captures with MEM/WB forwarding
        set_load_r8();
        tick();
        set_add_r9_r8_r8();
        #1 check("lu_stall", hazard_stall, 1);
        tick();
        check("lu_bubble_valid", ex_valid, 0);
        #1 check("lu_stall_fall", hazard_stall, 0);
        mwb_reg_write = 1; mwb_rd = 5'd8; mwb_data = 32'h10;
        tick();
        check("lu_add_valid", ex_valid, 1);
        check("lu_add_dest", ex_dest, 9);
        #1 check("lu_in1", alu_in1, 32'h10);
        check("lu_in2", alu_in2, 32'h10);

        // Flush coinciding with a stall
        set_load_r8();
        tick();
        set_add_r9_r8_r8();
        flush = 1;
        #1 check("fs_stall", hazard_stall, 1);
        tick();
        check("fs_valid", ex_valid, 0);
        check("fs_wr", {ex_reg_write, ex_mem_write}, 0);

        // Randomized traffic with occasional mid-stream reset
        for (int n = 0; n < 600; n++) begin
            rand_inputs();
            rst_n = ($urandom_range(0, 39) != 0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline stage feeding the ALU. It registers decoded operands and control from the decode stage and generates the 4-bit ALU control code from ALUOp/funct. It resolves data forwarding from the EX/MEM and MEM/WB stages and detects load-use hazards. Outputs drive the ALU's `aluCtrl`, `input1` and `input2`, plus the control bits passed down the pipe.

## Interface
- `W`, 32: datapath width.
- `clk`  in  1: the single clock; all state updates on its rising edge.
- `rst_n`  in  1: synchronous, active-low reset, sampled on the rising edge of `clk`.
- `id_valid`  in  1: decode slot holds a real instruction.
- `id_rs`, `id_rt`, `id_rd`  in  5 each: register specifiers.
- `id_rs_data`, `id_rt_data`  in  W: register file read data.
- `id_imm`  in  W: sign-extended immediate.
- `id_shamt`  in  5: shift amount.
- `id_funct`  in  6: R-type function field.
- `id_alu_op`  in  2: 00 add, 01 sub, 10 use funct, 11 or.
- `id_alu_src`, `id_reg_dst`, `id_reg_write`, `id_mem_read`, `id_mem_write`, `id_mem_to_reg`, `id_branch`  in  1 each: decoded control.
- `flush`  in  1: squash the instruction being loaded this cycle (taken branch).
- `exm_reg_write`  in  1, `exm_rd`  in  5, `exm_result`  in  W: EX/MEM forwarding source.
- `mwb_reg_write`  in  1, `mwb_rd`  in  5, `mwb_data`  in  W: MEM/WB forwarding source.
- `hazard_stall`  out  1: load-use stall request to PC and IF/ID.
- `ex_valid`  out  1: registered valid.
- `alu_ctrl`  out  4: ALU control code.
- `alu_in1`, `alu_in2`  out  W: ALU operands.
- `ex_store_data`  out  W: forwarded rt value for stores.
- `ex_dest`  out  5: destination register (rd if reg_dst, else rt).
- `ex_reg_write`, `ex_mem_read`, `ex_mem_write`, `ex_mem_to_reg`, `ex_branch`  out  1 each: registered control bits.
- `ex_illegal`  out  1: unsupported funct under ALUOp 10.

## Operation
- **ALU control codes:** 0000 AND, 0001 OR, 0010 ADD, 0011 SUB, 0100 SLL, 0101 SRL, 0110 SLT.
- **ALU control decode:** performed at capture and registered. ALUOp 00→0010, 01→0011, 11→0001. For ALUOp 10, funct maps as follows:
  - 100000→0010, 100010→0011, 100100→0000, 100101→0001, 101010→0110, 000000→0100, 000010→0101.
  - Any other funct→0010 with `ex_illegal`=1.
- **Capture:** each edge loads all `id_*` fields, the decoded control code and the destination.
- **Bubble:** the stage loads a bubble instead when `flush`=1 or `hazard_stall`=1. A bubble sets valid and all control bits to 0, `ex_illegal` to 0 and the code to 0010. Data registers may load but are don't-care.
- **Forwarding (combinational, per source operand rs/rt):**
  - Use `exm_result` if `exm_reg_write` and `exm_rd`!=0 and `exm_rd` matches.
  - Otherwise use `mwb_data` if `mwb_reg_write` and `mwb_rd`!=0 and `mwb_rd` matches.
  - Otherwise use the registered data. EX/MEM has priority.
  - Register 0 is never forwarded.
- **Operand select:**
  - Shift codes (0100/0101): `alu_in1` = forwarded rt, `alu_in2` = zero-extended shamt.
  - Otherwise: `alu_in1` = forwarded rs; `alu_in2` = `id_imm` (registered) if alu_src, else forwarded rt.
- `ex_store_data` = forwarded rt, always.
- **Load-use hazard:** `hazard_stall` = `ex_valid` & `ex_mem_read` & `ex_dest`!=0 & `id_valid` & (`ex_dest`==`id_rs` | `ex_dest`==`id_rt`). It is combinational and is not asserted for an `id_valid`=0 slot.

## Timing
- **Reset:** on an edge with `rst_n`=0, all registers clear to 0. `alu_ctrl` clears to 0010, `ex_valid`=0, every control output=0, `ex_dest`=0.
  - During reset, `hazard_stall`=0 because `ex_valid`=0.
  - Reset mid-stream discards the held instruction; there is no partial state.
- **Latency:** one cycle from `id_*` to the registered outputs.
- **Forwarding and hazard paths:** both are same-cycle combinational from the `exm_*`/`mwb_*` and `id_*` inputs, with no added latency.
- **Stall:** the upstream holds its outputs while `hazard_stall`=1. This stage inserts exactly one bubble per load-use. On the next cycle the load sits in EX/MEM, so `hazard_stall` falls and the held instruction is captured, with the operand then forwarded from MEM/WB.
- **Flush and stall together:** both yield a bubble. Flush does not suppress `hazard_stall`.
- **Back-to-back writers of the same register:** the younger one (EX/MEM) wins.

## Test plan
1. **Reset:** hold `rst_n`=0 for 2 edges with random `id_*` -> `ex_valid`=0, `alu_ctrl`=0010, all control outputs 0, `hazard_stall`=0.
2. **ALU control decode:** R-type add, sub, and, or, slt, sll, srl, plus funct 000011, with ALUOp 10 -> codes 0010, 0011, 0000, 0001, 0110, 0100, 0101, then 0010 with `ex_illegal`=1. ALUOp 00/01/11 -> 0010/0011/0001.
3. **Forwarding priority:** rs=5 with rf data 1. `exm_rd`=5 with `exm_result`=0xAA, and `mwb_rd`=5 with `mwb_data`=0xBB -> `alu_in1`=0xAA. Drop `exm_reg_write` -> 0xBB. Set all rd=0 -> 1.
4. **Load-use:** lw r8 followed by add r9,r8,r8 -> `hazard_stall`=1 for exactly one cycle, the next EX slot is a bubble, then the add captures. With `mwb_rd`=8 and `mwb_data`=0x10, `alu_in1`=`alu_in2`=0x10.
5. **Immediate and shift select:** addi with imm 0xFFFFFFFC and alu_src=1 -> `alu_in2`=0xFFFFFFFC. sll with shamt 3 and rt data 1 -> `alu_in1`=1, `alu_in2`=3.
6. **Flush during stall:** `flush`=1 while `hazard_stall`=1 -> bubble captured with `ex_valid`=0. `ex_reg_write`/`ex_mem_write` stay 0.
